// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side drain stage behind a synchronous FIFO.
// Issues FIFO reads (one-cycle read latency), parks returned words in a
// 3-entry circular skid buffer and presents them as a valid/ready stream
// grouped into BURST_LEN-word bursts marked by o_last.
//
// Handshake: a word transfers on a rising edge where o_valid && i_ready.
// o_data/o_last are held while o_valid && !i_ready. o_fifo_rd_en depends
// only on registered state and i_fifo_empty, never on i_ready.
//
// Optional feature: define FIFO_BURST_READER_STATS_EN to add the 16-bit
// o_burst_count output (completed bursts, wrapping).
//
// FSM state is visible on o_busy (high in BURST).

module fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4     // must be >= 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd_en,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_busy
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]      o_burst_count
`endif
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    logic [WIDTH-1:0]  mem [3];
    logic [1:0]        count;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic              inflight;
    logic [BEAT_W-1:0] beat;
    state_t            state;

    logic              push;
    logic              pop;
    logic [2:0]        credit_used;

    // Pointer increment with wrap 2 -> 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Every outstanding read owns a buffer slot, so a returning word
    // always finds room; reads are suppressed while reset is asserted.
    assign credit_used  = {1'b0, count} + {2'b00, inflight};
    assign o_fifo_rd_en = !i_rst && !i_fifo_empty && (credit_used < 3'd3);

    assign push    = inflight;
    assign o_valid = (count != 2'd0);
    assign pop     = o_valid && i_ready;
    assign o_data  = mem[rd_ptr];
    assign o_last  = o_valid && (beat == LAST_BEAT);
    assign o_busy  = (state == BURST);

    // Track the read issued last cycle; its data arrives this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= o_fifo_rd_en;
        end
    end

    // Skid buffer storage; cleared so o_data reads 0 out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= i_fifo_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Beat counter and burst FSM; a burst only closes on its last beat,
    // so a dry FIFO mid-burst leaves the block waiting in BURST.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat  <= '0;
            state <= IDLE;
        end else if (pop) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            case (state)
                IDLE: begin
                    state <= BURST;
                end
                BURST: begin
                    if (o_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    // Count completed bursts; wraps naturally at 16 bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_burst_count <= 16'd0;
        end else if (pop && o_last) begin
            o_burst_count <= o_burst_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain stage placed directly downstream of the synchronous FIFO. It issues FIFO reads (one-cycle read latency) and buffers the returned words in a 3-entry skid buffer. It presents them as a valid/ready stream, grouped into fixed-length bursts with an `o_last` marker. The block sustains one word per cycle, and no FIFO read enable depends combinationally on `i_ready`.

## Interface
- `WIDTH`, default 32: data word width; must match the FIFO `WIDTH`.
- `BURST_LEN`, default 4: words per burst; must be ≥2. Beat counter width is `$clog2(BURST_LEN)`.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_fifo_data`  in  WIDTH  FIFO `o_data`; valid the cycle after `o_fifo_rd_en` is sampled high.
- `i_fifo_empty`  in  1  FIFO `o_empty`.
- `o_fifo_rd_en`  out  1  FIFO `rd_en`.
- `o_data`  out  WIDTH  stream data (head of skid buffer).
- `o_valid`  out  1  stream word available.
- `i_ready`  in  1  downstream accepts the word when high together with `o_valid`.
- `o_last`  out  1  head word is the final beat of a burst.
- `o_busy`  out  1  high while a burst is partially transferred (state BURST).

## Operation
- Skid buffer: 3 entries, circular, with a 2-bit occupancy `count`.
- In-flight flag `inflight`: a registered copy of `o_fifo_rd_en`.
- `o_fifo_rd_en = !i_fifo_empty && (count + inflight) < 3`.
  - Uses registered state and `i_fifo_empty` only.
  - This guarantees a free entry for every returning word; overflow is impossible.
- Push: when `inflight` is 1, `i_fifo_data` is written at the write pointer that cycle.
- Pop: on `o_valid && i_ready`, the read pointer advances.
- Simultaneous push and pop: `count` is unchanged, and both pointers advance.
- Pointers wrap 2→0.
- `o_valid = (count != 0)`. `o_data` is the entry at the read pointer.
- Stream stability: while `o_valid && !i_ready`, `o_data` and `o_last` hold.
- Beat counter `beat` counts 0 to BURST_LEN-1.
  - It increments on each handshake and wraps to 0 after BURST_LEN-1.
  - `o_last = o_valid && (beat == BURST_LEN-1)`.
- State machine:
  - IDLE (`beat` == 0) → BURST on the first handshake.
  - BURST → IDLE on the handshake where `o_last` is 1.
  - `o_busy = (state == BURST)`.
- A burst is not closed early. If the FIFO runs dry mid-burst, the block stays in BURST with `o_valid` = 0 until more words arrive.

## Timing
- Reset values: `o_valid` 0, `o_last` 0, `o_busy` 0, `o_data` 0, `o_fifo_rd_en` 0. Internal state: `count` 0, `inflight` 0, pointers 0, `beat` 0, state IDLE.
- Reset asserted mid-operation:
  - Everything clears immediately, without waiting for a clock edge.
  - Buffered words and any word in flight from the FIFO are discarded.
  - System rule: the FIFO is reset together with this block.
- Latency: `i_fifo_empty` falls at cycle N → `o_fifo_rd_en` high in cycle N → word latched at edge N+2 → `o_valid` high in cycle N+2 (2 cycles).
- Throughput: with `i_ready` held high and the FIFO non-empty, one handshake per cycle, sustained.
- Backpressure: after `i_ready` drops, at most 3 words are held. `o_fifo_rd_en` falls within 1 cycle of the buffer reaching its credit limit.
- FIFO goes empty while a read is in flight: the in-flight word is still pushed, and no further read is issued.

## Configuration
- `FIFO_BURST_READER_STATS_EN` defined:
  - Adds output `o_burst_count` (16 bits, reset 0).
  - Increments on each handshake with `o_last` = 1.
  - Wraps from 0xFFFF to 0.
- Macro not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, FIFO empty, `i_ready` = 1 → `o_valid`, `o_fifo_rd_en`, `o_last`, `o_busy` all 0 for 20 cycles.
- Write 8 words 0x1..0x8 into the FIFO, `i_ready` = 1 → 8 consecutive handshakes carrying 0x1..0x8.
  - `o_last` high on 0x4 and 0x8.
  - `o_busy` low after 0x8.
  - First `o_valid` 2 cycles after `o_empty` falls.
- 10 words queued, `i_ready` = 0 for 6 cycles → exactly 3 FIFO reads occur.
  - `o_data` = first word, held stable.
  - On `i_ready` = 1, the remaining words arrive in order with no loss or duplication.
- 6 words queued, `i_ready` = 1 → words 1–4 form a burst (`o_last` on word 4).
  - Words 5–6 leave `o_busy` = 1.
  - Writing 2 more words completes the burst, with `o_last` on word 8.
- Reset asserted mid-burst (2 words buffered, 1 in flight); FIFO and block reset together → all outputs 0 immediately, `beat` restarts at 0, and the next burst's `o_last` falls on its 4th word.
- With `FIFO_BURST_READER_STATS_EN`, stream 12 words → `o_burst_count` = 3. Without the macro, the same run completes identically.
